// File: rtl/pe_cluster_iact_mcast.sv
// Iact multicast distributor: per-channel beat hold with per-PE delivery.
// Ports: clk/rst, conf_* map writes, in_* channel beats, pe_* PE beats,
//   busy (any channel delivering), cfg_err, drop_cnt (unmatched beats).
module pe_cluster_iact_mcast #(
   parameter int NUM_CH     = 3,
   parameter int NUM_PE     = 12,
   parameter int DATA_WIDTH = 24,
   parameter int SET_WIDTH  = 2,
   parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int PE_W       = (NUM_PE > 1) ? $clog2(NUM_PE) : 1,
   parameter int CFG_W      = 1 + CH_W + SET_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           conf_rst,
   input  logic                           conf_en,
   input  logic [PE_W-1:0]                conf_addr,
   input  logic [CFG_W-1:0]               conf_data,
   input  logic [NUM_CH-1:0]              in_valid,
   output logic [NUM_CH-1:0]              in_ready,
   input  logic [NUM_CH*DATA_WIDTH-1:0]   in_data,
   input  logic [NUM_CH*SET_WIDTH-1:0]    in_set,
   output logic [NUM_PE-1:0]              pe_valid,
   input  logic [NUM_PE-1:0]              pe_ready,
   output logic [NUM_PE*DATA_WIDTH-1:0]   pe_data,
   output logic                           busy,
   output logic                           cfg_err,
   output logic [15:0]                    drop_cnt
);

   typedef enum logic {S_IDLE = 1'b0, S_DELIVER = 1'b1} state_t;

   logic                  ent_v   [NUM_PE];
   logic [CH_W-1:0]       ent_ch  [NUM_PE];
   logic [SET_WIDTH-1:0]  ent_set [NUM_PE];

   state_t                state_q [NUM_CH];
   state_t                state_d [NUM_CH];
   logic [NUM_PE-1:0]     pend_q  [NUM_CH];
   logic [NUM_PE-1:0]     pend_d  [NUM_CH];
   logic [DATA_WIDTH-1:0] hold_q  [NUM_CH];

   logic [NUM_PE-1:0]     match   [NUM_CH];
   logic [NUM_PE-1:0]     done    [NUM_CH];
   logic [NUM_CH-1:0]     accept;
   logic [NUM_CH-1:0]     drop;
   logic [16:0]           drop_add;
   logic [16:0]           drop_sum;
   logic [15:0]           drop_nxt;

   logic                  conf_v;
   logic [CH_W-1:0]       conf_ch;
   logic [SET_WIDTH-1:0]  conf_set;
   logic                  conf_bad;
   logic                  conf_wr;

   assign conf_v   = conf_data[CFG_W-1];
   assign conf_ch  = conf_data[SET_WIDTH +: CH_W];
   assign conf_set = conf_data[SET_WIDTH-1:0];

   assign conf_bad = busy
                   | (int'(conf_addr) >= NUM_PE)
                   | (int'(conf_ch) >= NUM_CH);
   assign conf_wr  = conf_en & ~conf_rst & ~conf_bad;

   // FSM outputs: in_ready never looks at pe_ready, only registered state.
   always_comb begin
      busy = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         in_ready[c] = (state_q[c] == S_IDLE) & ~conf_rst;
         busy        = busy | (state_q[c] == S_DELIVER);
      end
   end

   assign accept = in_valid & in_ready;

   // done also retires a bit whose PE no longer maps to this channel,
   // so a remap landing on the accept edge cannot strand the channel.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         for (int p = 0; p < NUM_PE; p++) begin
            match[c][p] = ent_v[p]
                        & (ent_ch[p] == CH_W'(c))
                        & (ent_set[p] == in_set[c*SET_WIDTH +: SET_WIDTH]);
            done[c][p]  = pe_ready[p]
                        | ~(ent_v[p] & (ent_ch[p] == CH_W'(c)));
         end
         drop[c] = accept[c] & ~(|match[c]);
      end
   end

   // FSM next state
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         state_d[c] = state_q[c];
         pend_d[c]  = pend_q[c];
         if (conf_rst) begin
            state_d[c] = S_IDLE;
            pend_d[c]  = '0;
         end else begin
            unique case (state_q[c])
               S_IDLE: begin
                  if (accept[c] && (|match[c])) begin
                     state_d[c] = S_DELIVER;
                     pend_d[c]  = match[c];
                  end
               end
               S_DELIVER: begin
                  pend_d[c] = pend_q[c] & ~done[c];
                  if ((pend_q[c] & ~done[c]) == '0) begin
                     state_d[c] = S_IDLE;
                  end
               end
            endcase
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c] <= S_IDLE;
            pend_q[c]  <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c] <= state_d[c];
            pend_q[c]  <= pend_d[c];
         end
      end
   end

   // Several channels may drop together; add them all, then saturate.
   always_comb begin
      drop_add = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         drop_add = drop_add + 17'(drop[c]);
      end
      drop_sum = {1'b0, drop_cnt} + drop_add;
      drop_nxt = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            hold_q[c] <= '0;
         end
         drop_cnt <= '0;
         cfg_err  <= 1'b0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (accept[c]) begin
               hold_q[c] <= in_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         drop_cnt <= drop_nxt;
         cfg_err  <= conf_en & ~conf_rst & conf_bad;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < NUM_PE; p++) begin
            ent_v[p]   <= 1'b0;
            ent_ch[p]  <= '0;
            ent_set[p] <= '0;
         end
      end else if (conf_rst) begin
         for (int p = 0; p < NUM_PE; p++) begin
            ent_v[p]   <= 1'b0;
            ent_ch[p]  <= '0;
            ent_set[p] <= '0;
         end
      end else if (conf_wr) begin
         ent_v[conf_addr]   <= conf_v;
         ent_ch[conf_addr]  <= conf_ch;
         ent_set[conf_addr] <= conf_set;
      end
   end

   // Each PE listens to exactly one channel, so this is a plain mux.
   always_comb begin
      pe_valid = '0;
      pe_data  = '0;
      for (int p = 0; p < NUM_PE; p++) begin
         if (ent_v[p] && (int'(ent_ch[p]) < NUM_CH)) begin
            pe_valid[p] = pend_q[ent_ch[p]][p];
            pe_data[p*DATA_WIDTH +: DATA_WIDTH] = hold_q[ent_ch[p]];
         end
      end
   end

endmodule
